// File: rtl/mult_arbiter.sv
// Two-requester round-robin arbiter in front of one combinational N x N multiplier.
// Latency: accept edge -> LAT CALC cycles -> result held in DONE; rsp_valid first sampled high LAT+1 edges after accept.
// Backpressure: requesters are stalled (ready low) from accept until the result is taken with rsp_ready.
module mult_arbiter #(
    parameter int N   = 4,
    parameter int LAT = 1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [N-1:0]   req0_b,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [N-1:0]   req1_b,
    output logic           rsp_valid,
    input  logic           rsp_ready,
    output logic [2*N-1:0] rsp_data,
    output logic           rsp_id,
    output logic           busy
);

    localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N-1:0]     a_q, a_d;
    logic [N-1:0]     b_q, b_d;
    logic             id_q, id_d;
    logic             last_q, last_d;
    logic [2*N-1:0]   data_q, data_d;

    logic             gnt0, gnt1;
    logic [2*N-1:0]   prod;

    // Single multiplier, driven only from the operand registers.
    assign prod = {{N{1'b0}}, a_q} * {{N{1'b0}}, b_q};

    // On contention the requester not served last wins.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (state_q == IDLE) begin
            if (req0_valid && req1_valid) begin
                if (last_q) gnt0 = 1'b1;
                else        gnt1 = 1'b1;
            end else if (req0_valid) begin
                gnt0 = 1'b1;
            end else if (req1_valid) begin
                gnt1 = 1'b1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        id_d    = id_q;
        last_d  = last_q;
        data_d  = data_q;
        unique case (state_q)
            IDLE: begin
                if (gnt0 || gnt1) begin
                    a_d     = gnt1 ? req1_a : req0_a;
                    b_d     = gnt1 ? req1_b : req0_b;
                    id_d    = gnt1;
                    last_d  = gnt1;
                    cnt_d   = CNT_INIT;
                    state_d = CALC;
                end
            end
            CALC: begin
                if (cnt_q == '0) begin
                    data_d  = prod;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            id_q    <= 1'b0;
            last_q  <= 1'b1;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            id_q    <= id_d;
            last_q  <= last_d;
            data_q  <= data_d;
        end
    end

    assign req0_ready = gnt0;
    assign req1_ready = gnt1;
    assign rsp_valid  = (state_q == DONE);
    assign rsp_data   = data_q;
    assign rsp_id     = id_q;
    assign busy       = (state_q != IDLE);

endmodule
